// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: datapath width, the reset and bubble
// constants, the next-PC select encoding, and the IF/ID register payload.
package mips_pkg;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned JIDX_W   = 26;

    // sll $0,$0,0 -- the architectural no-op used as a pipeline bubble
    localparam logic [XLEN-1:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP          = 32'h0000_0004;

    typedef enum logic [1:0] {
        PC_SEQ = 2'd0,
        PC_BR  = 2'd1,
        PC_J   = 2'd2,
        PC_JR  = 2'd3
    } pc_sel_e;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus4;
        logic            valid;
    } ifid_t;

    // Bubble payload written on reset, redirect and flush
    function automatic ifid_t ifid_bubble(input logic [XLEN-1:0] nop);
        ifid_t b;
        b.instr    = nop;
        b.pc_plus4 = '0;
        b.valid    = 1'b0;
        return b;
    endfunction

endpackage

// File: rtl/pc_next_select.sv
// Next-PC selection for the fetch stage (purely combinational).
// Ports:
//   i_pc               current PC register
//   i_stall            hold request from the hazard unit
//   i_branch/_base_pc/_offset   taken conditional branch and its operands
//   i_jump/_index/_base_pc      taken j/jal and its operands
//   i_jump_reg/_addr            taken jr and its register operand
//   o_pc_plus4_c       PC+4 of the current PC
//   o_next_pc_c        value the PC register loads at the next edge
//   o_redirect_c       1 when a branch/jump/jr replaces the sequential path
module pc_next_select
    import mips_pkg::*;
(
    input  logic [XLEN-1:0]   i_pc,
    input  logic              i_stall,
    input  logic              i_branch,
    input  logic [XLEN-1:0]   i_branch_base_pc,
    input  logic [XLEN-1:0]   i_branch_offset,
    input  logic              i_jump,
    input  logic [JIDX_W-1:0] i_jump_index,
    input  logic [XLEN-1:0]   i_jump_base_pc,
    input  logic              i_jump_reg,
    input  logic [XLEN-1:0]   i_jump_reg_addr,
    output logic [XLEN-1:0]   o_pc_plus4_c,
    output logic [XLEN-1:0]   o_next_pc_c,
    output logic              o_redirect_c
);

    logic [XLEN-1:0] w_br_target;
    logic [XLEN-1:0] w_j_target;
    logic [XLEN-1:0] w_jr_target;
    pc_sel_e         w_sel;

    // Only the segment bits of the jump base and the word bits of the jr
    // operand matter; the rest are intentionally ignored.
    logic w_unused;
    assign w_unused = &{1'b0, i_jump_base_pc[27:0], i_jump_reg_addr[1:0]};

    // Target arithmetic, all modulo 2^32
    always_comb begin
        o_pc_plus4_c = i_pc + PC_STEP;
        w_br_target  = i_branch_base_pc + (i_branch_offset << 2);
        w_j_target   = {i_jump_base_pc[31:28], i_jump_index, 2'b00};
        w_jr_target  = {i_jump_reg_addr[31:2], 2'b00};
    end

    // Priority: jr > j > branch > sequential
    always_comb begin
        w_sel = PC_SEQ;
        if (i_jump_reg) begin
            w_sel = PC_JR;
        end else if (i_jump) begin
            w_sel = PC_J;
        end else if (i_branch) begin
            w_sel = PC_BR;
        end
    end

    // A redirect overrides stall since the stalled instruction is wrong-path
    always_comb begin
        o_next_pc_c  = o_pc_plus4_c;
        o_redirect_c = (w_sel != PC_SEQ);
        unique case (w_sel)
            PC_JR:   o_next_pc_c = w_jr_target;
            PC_J:    o_next_pc_c = w_j_target;
            PC_BR:   o_next_pc_c = w_br_target;
            default: o_next_pc_c = i_stall ? i_pc : o_pc_plus4_c;
        endcase
    end

endmodule

// File: rtl/instruction_fetch_unit.sv
// MIPS fetch stage: owns the PC, addresses instruction memory and fills the
// IF/ID pipeline register, honouring redirects, stalls and flushes.
// Ports:
//   Clk, Rst            clock and synchronous active-high reset
//   Address             PC register, byte address to instruction memory
//   Instruction         combinational memory word for Address
//   Stall, Flush        hazard-unit hold / bubble-insert requests
//   Branch*, Jump*, JumpReg*   redirect requests and operands
//   IFID_Instruction, IFID_PCPlus4, IFID_Valid   registered IF/ID contents
module instruction_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [XLEN-1:0] NOP      = NOP_WORD
) (
    input  logic              Clk,
    input  logic              Rst,
    output logic [XLEN-1:0]   Address,
    input  logic [XLEN-1:0]   Instruction,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              Branch,
    input  logic [XLEN-1:0]   BranchBasePC,
    input  logic [XLEN-1:0]   BranchOffset,
    input  logic              Jump,
    input  logic [JIDX_W-1:0] JumpIndex,
    input  logic [XLEN-1:0]   JumpBasePC,
    input  logic              JumpReg,
    input  logic [XLEN-1:0]   JumpRegAddr,
    output logic [XLEN-1:0]   IFID_Instruction,
    output logic [XLEN-1:0]   IFID_PCPlus4,
    output logic              IFID_Valid
);

    logic [XLEN-1:0] r_pc;
    ifid_t           r_ifid;

    logic [XLEN-1:0] w_pc_plus4;
    logic [XLEN-1:0] w_next_pc;
    logic            w_redirect;
    ifid_t           w_ifid_next;

    pc_next_select u_pc_next_select (
        .i_pc             (r_pc),
        .i_stall          (Stall),
        .i_branch         (Branch),
        .i_branch_base_pc (BranchBasePC),
        .i_branch_offset  (BranchOffset),
        .i_jump           (Jump),
        .i_jump_index     (JumpIndex),
        .i_jump_base_pc   (JumpBasePC),
        .i_jump_reg       (JumpReg),
        .i_jump_reg_addr  (JumpRegAddr),
        .o_pc_plus4_c     (w_pc_plus4),
        .o_next_pc_c      (w_next_pc),
        .o_redirect_c     (w_redirect)
    );

    // IF/ID next-value: redirect and flush insert a bubble, stall holds
    always_comb begin
        w_ifid_next          = r_ifid;
        if (w_redirect || Flush) begin
            w_ifid_next = ifid_bubble(NOP);
        end else if (!Stall) begin
            w_ifid_next.instr    = Instruction;
            w_ifid_next.pc_plus4 = w_pc_plus4;
            w_ifid_next.valid    = 1'b1;
        end
    end

    // PC and IF/ID registers; reset discards every same-cycle request
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_pc   <= RESET_PC;
            r_ifid <= ifid_bubble(NOP);
        end else begin
            r_pc   <= w_next_pc;
            r_ifid <= w_ifid_next;
        end
    end

    assign Address          = r_pc;
    assign IFID_Instruction = r_ifid.instr;
    assign IFID_PCPlus4     = r_ifid.pc_plus4;
    assign IFID_Valid       = r_ifid.valid;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed
// by randomized control traffic, compared against a behavioural model.
module tb_instruction_fetch_unit;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] Address;
    logic [31:0] Instruction;
    logic        Stall, Flush, Branch, Jump, JumpReg;
    logic [31:0] BranchBasePC, BranchOffset, JumpBasePC, JumpRegAddr;
    logic [25:0] JumpIndex;
    logic [31:0] IFID_Instruction, IFID_PCPlus4;
    logic        IFID_Valid;

    int n_cmp = 0;
    int n_err = 0;

    // reference model state
    logic [31:0] m_pc, m_instr, m_p4;
    logic        m_valid;

    always #5 Clk = ~Clk;

    instruction_fetch_unit dut (
        .Clk(Clk), .Rst(Rst), .Address(Address), .Instruction(Instruction),
        .Stall(Stall), .Flush(Flush),
        .Branch(Branch), .BranchBasePC(BranchBasePC), .BranchOffset(BranchOffset),
        .Jump(Jump), .JumpIndex(JumpIndex), .JumpBasePC(JumpBasePC),
        .JumpReg(JumpReg), .JumpRegAddr(JumpRegAddr),
        .IFID_Instruction(IFID_Instruction), .IFID_PCPlus4(IFID_PCPlus4),
        .IFID_Valid(IFID_Valid)
    );

    // Instruction memory image: three program words, hashed filler elsewhere
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h0: return 32'h200A_0001;
            32'h4: return 32'h200B_0005;
            32'h8: return 32'h2129_0001;
            default: return {a[15:0] ^ 16'h5A5A, a[31:16] + 16'h1357};
        endcase
    endfunction

    assign Instruction = mem_word(Address);

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic clear_ctl();
        Rst = 1'b0; Stall = 1'b0; Flush = 1'b0;
        Branch = 1'b0; Jump = 1'b0; JumpReg = 1'b0;
        BranchBasePC = '0; BranchOffset = '0;
        JumpIndex = '0; JumpBasePC = '0; JumpRegAddr = '0;
    endtask

    // Advance one clock: predict from the rules, clock, then compare
    task automatic tick();
        logic [31:0] n_pc, n_instr, n_p4;
        logic        n_valid;
        logic        bubble;
        n_pc = m_pc; n_instr = m_instr; n_p4 = m_p4; n_valid = m_valid;
        bubble = 1'b0;
        if (Rst) begin
            n_pc = 32'h0; bubble = 1'b1;
        end else if (JumpReg) begin
            n_pc = JumpRegAddr & 32'hFFFF_FFFC; bubble = 1'b1;
        end else if (Jump) begin
            n_pc = {JumpBasePC[31:28], JumpIndex, 2'b00}; bubble = 1'b1;
        end else if (Branch) begin
            n_pc = BranchBasePC + BranchOffset * 32'd4; bubble = 1'b1;
        end else if (Stall) begin
            bubble = Flush;
        end else begin
            n_pc = m_pc + 32'd4;
            if (Flush) begin
                bubble = 1'b1;
            end else begin
                n_instr = mem_word(m_pc); n_p4 = m_pc + 32'd4; n_valid = 1'b1;
            end
        end
        if (bubble) begin
            n_instr = 32'h0; n_p4 = 32'h0; n_valid = 1'b0;
        end
        @(posedge Clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_p4 = n_p4; m_valid = n_valid;
        check_eq("address", Address, m_pc);
        check_eq("ifid_instr", IFID_Instruction, m_instr);
        check_eq("ifid_pc4", IFID_PCPlus4, m_p4);
        check_eq("ifid_valid", 32'(IFID_Valid), 32'(m_valid));
    endtask

    initial begin
        m_pc = '0; m_instr = '0; m_p4 = '0; m_valid = 1'b0;
        clear_ctl();
        Rst = 1'b1;
        tick();
        check_eq("reset_addr", Address, 32'h0);
        check_eq("reset_valid", 32'(IFID_Valid), 32'h0);
        clear_ctl();

        // sequential fetch of the program
        tick();
        check_eq("seq_addr4", Address, 32'h4);
        check_eq("seq_i0", IFID_Instruction, 32'h200A_0001);
        check_eq("seq_p4_0", IFID_PCPlus4, 32'h4);
        tick();
        check_eq("seq_i1", IFID_Instruction, 32'h200B_0005);
        check_eq("seq_p4_1", IFID_PCPlus4, 32'h8);
        tick();
        check_eq("seq_addrC", Address, 32'hC);

        // stall two cycles at 0xC
        Stall = 1'b1;
        tick();
        tick();
        check_eq("stall_addr", Address, 32'hC);
        check_eq("stall_i", IFID_Instruction, 32'h2129_0001);

        // stall with branch: redirect wins
        Branch = 1'b1; BranchBasePC = 32'h10; BranchOffset = 32'hFFFF_FFFE;
        tick();
        check_eq("br_addr", Address, 32'h8);
        check_eq("br_valid", 32'(IFID_Valid), 32'h0);
        clear_ctl();

        // jump alone, then jump over a simultaneous branch to 0x40
        Jump = 1'b1; JumpIndex = 26'h2; JumpBasePC = 32'h18;
        tick();
        check_eq("j_addr", Address, 32'h8);
        tick();
        Branch = 1'b1; BranchBasePC = 32'h38; BranchOffset = 32'h2;
        tick();
        check_eq("j_over_br", Address, 32'h8);
        clear_ctl();

        // jr forces low bits to zero and beats jump
        JumpReg = 1'b1; JumpRegAddr = 32'h23;
        Jump = 1'b1; JumpIndex = 26'h2; JumpBasePC = 32'h18;
        tick();
        check_eq("jr_addr", Address, 32'h20);
        clear_ctl();

        // flush during stall, then flush alone
        tick();
        Stall = 1'b1; Flush = 1'b1;
        tick();
        check_eq("stflush_addr", Address, 32'h24);
        Stall = 1'b0;
        tick();
        clear_ctl();
        tick();

        // reset beats stall and branch
        JumpReg = 1'b1; JumpRegAddr = 32'h40;
        tick();
        clear_ctl();
        Rst = 1'b1; Stall = 1'b1; Branch = 1'b1;
        BranchBasePC = 32'h100; BranchOffset = 32'h4;
        tick();
        check_eq("rst_mid_addr", Address, 32'h0);
        check_eq("rst_mid_i", IFID_Instruction, 32'h0);
        clear_ctl();

        // wrap-around from the last word
        JumpReg = 1'b1; JumpRegAddr = 32'hFFFF_FFFF;
        tick();
        check_eq("top_addr", Address, 32'hFFFF_FFFC);
        clear_ctl();
        tick();
        check_eq("wrap_addr", Address, 32'h0);
        check_eq("wrap_p4", IFID_PCPlus4, 32'h0);

        // randomized control traffic
        for (int i = 0; i < 3000; i++) begin
            Rst          = ($urandom_range(63) == 0);
            JumpReg      = ($urandom_range(15) == 0);
            Jump         = ($urandom_range(15) == 0);
            Branch       = ($urandom_range(7) == 0);
            Stall        = ($urandom_range(4) == 0);
            Flush        = ($urandom_range(7) == 0);
            BranchBasePC = $urandom;
            BranchOffset = {{16{$urandom_range(1) == 1}}, 16'($urandom)};
            JumpIndex    = 26'($urandom);
            JumpBasePC   = $urandom;
            JumpRegAddr  = $urandom;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
